reset_sequencer: RTL and testbench

// Orders release of N_DOMAINS downstream reset domains after system reset or
// a runtime reset request. Each released domain must report ready before the

---
 rtl/reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_reset_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Releases N_DOMAINS reset domains in order once the hold period ends, waiting for each
// domain's ready (or a timeout) plus a fixed gap before the next release; any request restarts.
module reset_sequencer #(
  parameter int N_DOMAINS   = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_sw,
  input  logic                 req_wdog,
  input  logic                 req_dbg,
  input  logic [N_DOMAINS-1:0] domain_ready,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 busy,
  output logic [1:0]           cause,
  output logic [N_DOMAINS-1:0] timeout_err
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = $clog2(N_DOMAINS);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RELEASE,
    S_WAIT,
    S_GAP,
    S_RUN
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        ctr, ctr_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [N_DOMAINS-1:0] drst_nxt, terr_nxt;
  logic [1:0]           cause_nxt;
  logic                 busy_nxt;
  logic                 req_any;

  assign req_any = req_wdog | req_dbg | req_sw;

  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    idx_nxt   = idx;
    drst_nxt  = domain_rst;
    terr_nxt  = timeout_err;
    cause_nxt = cause;

    // A request beats any ready/timeout event in the same cycle.
    if (req_any) begin
      state_nxt = S_HOLD;
      ctr_nxt   = '0;
      idx_nxt   = '0;
      drst_nxt  = '1;
      if (req_wdog)     cause_nxt = 2'd1;
      else if (req_dbg) cause_nxt = 2'd2;
      else              cause_nxt = 2'd3;
    end else begin
      unique case (state)
        S_HOLD: begin
          drst_nxt = '1;
          if (ctr == HOLD_LAST) begin
            state_nxt = S_RELEASE;
            ctr_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            ctr_nxt = ctr + CW'(1);
          end
        end
        S_RELEASE: begin
          drst_nxt[idx] = 1'b0;
          state_nxt     = S_WAIT;
          ctr_nxt       = '0;
        end
        S_WAIT: begin
          if (domain_ready[idx]) begin
            state_nxt = S_GAP;
            ctr_nxt   = '0;
          end else if (ctr == TO_LAST) begin
            // Domain stays released; only the sticky flag records the miss.
            terr_nxt[idx] = 1'b1;
            state_nxt     = S_GAP;
            ctr_nxt       = '0;
          end else begin
            ctr_nxt = ctr + CW'(1);
          end
        end
        S_GAP: begin
          if (ctr == GAP_LAST) begin
            ctr_nxt = '0;
            if (idx == IDX_LAST) begin
              state_nxt = S_RUN;
            end else begin
              idx_nxt   = idx + IW'(1);
              state_nxt = S_RELEASE;
            end
          end else begin
            ctr_nxt = ctr + CW'(1);
          end
        end
        S_RUN: begin
          drst_nxt = '0;
        end
        default: begin
          state_nxt = S_HOLD;
          ctr_nxt   = '0;
          idx_nxt   = '0;
          drst_nxt  = '1;
        end
      endcase
    end

    busy_nxt = (state_nxt != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HOLD;
      ctr         <= '0;
      idx         <= '0;
      domain_rst  <= '1;
      busy        <= 1'b1;
      cause       <= 2'd0;
      timeout_err <= '0;
    end else begin
      state       <= state_nxt;
      ctr         <= ctr_nxt;
      idx         <= idx_nxt;
      domain_rst  <= drst_nxt;
      busy        <= busy_nxt;
      cause       <= cause_nxt;
      timeout_err <= terr_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timestamp-based release model checked every cycle,
// directed scenarios with literal edge timings, then randomized requests/ready/reset.
module tb_reset_sequencer;
  localparam int N    = 4;
  localparam int HOLD = 16;
  localparam int GAP  = 8;
  localparam int TO   = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_sw, req_wdog, req_dbg;
  logic [N-1:0] domain_ready;
  logic [N-1:0] domain_rst;
  logic         busy;
  logic [1:0]   cause;
  logic [N-1:0] timeout_err;

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_DOMAINS  (N),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_sw      (req_sw),
    .req_wdog    (req_wdog),
    .req_dbg     (req_dbg),
    .domain_ready(domain_ready),
    .domain_rst  (domain_rst),
    .busy        (busy),
    .cause       (cause),
    .timeout_err (timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t counts request-free edges since the sequence (re)started. Each domain has
  // a release timestamp; its ack timestamp sets the next release GAP+1 edges later.
  logic [N-1:0] m_rst, m_terr;
  logic         m_busy;
  logic [1:0]   m_cause;
  int           t, rel_t, run_t, k;
  bit           waiting;
  bit           model_ok = 1'b0;

  task automatic model_restart();
    m_rst   = '1;
    m_busy  = 1'b1;
    t       = 0;
    rel_t   = HOLD + 1;
    run_t   = -1;
    k       = 0;
    waiting = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        model_restart();
        m_terr   = '0;
        m_cause  = 2'd0;
        model_ok = 1'b1;
      end else if (req_wdog || req_dbg || req_sw) begin
        model_restart();
        m_cause = req_wdog ? 2'd1 : (req_dbg ? 2'd2 : 2'd3);
      end else if (model_ok) begin
        t++;
        if (t == rel_t) begin
          m_rst[k] = 1'b0;
          waiting  = 1'b1;
        end else if (waiting && (domain_ready[k] || (t - rel_t == TO))) begin
          if (!domain_ready[k]) m_terr[k] = 1'b1;
          waiting = 1'b0;
          if (k == N - 1) begin
            run_t = t + GAP;
          end else begin
            rel_t = t + GAP + 1;
            k++;
          end
        end
        if (t == run_t) m_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_ok) begin
        check("model_domain_rst", 32'(domain_rst), 32'(m_rst));
        check("model_busy", 32'(busy), 32'(m_busy));
        check("model_cause", 32'(cause), 32'(m_cause));
        check("model_timeout_err", 32'(timeout_err), 32'(m_terr));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_domain_rst"}, 32'(domain_rst), 32'hf);
    check({tag, "_busy"}, 32'(busy), 32'h1);
    check({tag, "_cause"}, 32'(cause), 32'h0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
  endtask

  bit wd_on, dbg_on;
  int ready_mode;
  logic [N-1:0] ready_pat;

  initial begin
    rst          = 1'b1;
    req_sw       = 1'b0;
    req_wdog     = 1'b0;
    req_dbg      = 1'b0;
    domain_ready = '1;

    // 1: ready tied high, release edges 17/27/37/47, busy falls at 56
    cyc(3);
    check_reset_vals("t1_reset");
    rst = 1'b0;
    cyc(16); check("t1_e16_rst", 32'(domain_rst), 32'hf);
    cyc(1);  check("t1_e17_rst", 32'(domain_rst), 32'he);
    cyc(10); check("t1_e27_rst", 32'(domain_rst), 32'hc);
    cyc(10); check("t1_e37_rst", 32'(domain_rst), 32'h8);
    cyc(10); check("t1_e47_rst", 32'(domain_rst), 32'h0);
    cyc(8);  check("t1_e55_busy", 32'(busy), 32'h1);
    cyc(1);  check("t1_e56_busy", 32'(busy), 32'h0);
    check("t1_cause", 32'(cause), 32'h0);

    // 2: domain 2 never ready; timeout at edge 292, RUN at 310
    rst = 1'b1;
    domain_ready = 4'b1011;
    cyc(2);
    rst = 1'b0;
    cyc(291); check("t2_e291_terr", 32'(timeout_err), 32'h0);
    cyc(1);   check("t2_e292_terr", 32'(timeout_err), 32'h4);
    cyc(17);  check("t2_e309_busy", 32'(busy), 32'h1);
    cyc(1);   check("t2_e310_busy", 32'(busy), 32'h0);
    check("t2_e310_rst", 32'(domain_rst), 32'h0);

    // 3: software pulse in RUN restarts with identical timing
    req_sw = 1'b1;
    cyc(1);
    req_sw = 1'b0;
    check("t3_rst_all", 32'(domain_rst), 32'hf);
    check("t3_cause", 32'(cause), 32'h3);
    check("t3_busy", 32'(busy), 32'h1);
    cyc(16);  check("t3_e16_rst", 32'(domain_rst), 32'hf);
    cyc(1);   check("t3_e17_rst", 32'(domain_rst), 32'he);
    cyc(293); check("t3_e310_busy", 32'(busy), 32'h0);
    check("t3_terr_kept", 32'(timeout_err), 32'h4);

    // 4: debugger request held 40 cycles
    req_dbg = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      check("t4_held_rst", 32'(domain_rst), 32'hf);
    end
    req_dbg = 1'b0;
    check("t4_cause", 32'(cause), 32'h2);
    cyc(16); check("t4_e16_rst", 32'(domain_rst), 32'hf);
    cyc(1);  check("t4_e17_rst", 32'(domain_rst), 32'he);

    // 5: wdog + sw together in the middle of domain 1's gap (edge 32)
    cyc(14);
    check("t5_pre_rst", 32'(domain_rst), 32'hc);
    req_wdog = 1'b1;
    req_sw   = 1'b1;
    cyc(1);
    req_wdog = 1'b0;
    req_sw   = 1'b0;
    check("t5_cause", 32'(cause), 32'h1);
    check("t5_rst_all", 32'(domain_rst), 32'hf);
    check("t5_terr_kept", 32'(timeout_err), 32'h4);
    cyc(16); check("t5_e16_rst", 32'(domain_rst), 32'hf);
    cyc(1);  check("t5_e17_rst", 32'(domain_rst), 32'he);

    // 6: reset asserted while waiting on domain 3 after domain 2 timed out
    domain_ready = 4'b0011;
    cyc(288);
    check("t6_terr_before", 32'(timeout_err), 32'h4);
    check("t6_rst_before", 32'(domain_rst), 32'h0);
    check("t6_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    cyc(1);
    check_reset_vals("t6_after_rst");
    rst = 1'b0;

    // 7: randomized requests, ready behaviour and occasional reset
    wd_on      = 1'b0;
    dbg_on     = 1'b0;
    ready_mode = 0;
    ready_pat  = '1;
    for (int c = 0; c < 20000; c++) begin
      if (c % 500 == 0) begin
        ready_mode = $urandom_range(0, 2);
        ready_pat  = N'($urandom);
      end
      case (ready_mode)
        0:       domain_ready = '1;
        1: begin
          for (int d = 0; d < N; d++) domain_ready[d] = ($urandom_range(0, 47) == 0);
        end
        default: domain_ready = ready_pat;
      endcase
      rst    = ($urandom_range(0, 2999) == 0);
      req_sw = ($urandom_range(0, 799) == 0);
      if (wd_on) wd_on = ($urandom_range(0, 19) != 0);
      else       wd_on = ($urandom_range(0, 1499) == 0);
      if (dbg_on) dbg_on = ($urandom_range(0, 19) != 0);
      else        dbg_on = ($urandom_range(0, 1499) == 0);
      req_wdog = wd_on;
      req_dbg  = dbg_on;
      cyc(1);
    end
    rst      = 1'b0;
    req_sw   = 1'b0;
    req_wdog = 1'b0;
    req_dbg  = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
